// File: rtl/sd_spi_pkg.sv
// Shared constants and FSM state type for the SD-card SPI byte master.
package sd_spi_pkg;

    localparam int SD_DIV_SLOW = 125;
    localparam int SD_DIV_FAST = 2;
    localparam int SD_BYTE_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        LOW,
        HIGH
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter: tick marks the last clk cycle of each SCK phase.
module spi_clk_div (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] cnt;

    assign tick = (cnt == div - 8'd1);

    // Restarting on tick keeps the count in 0..div-1 without wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 8'd1;
    end

endmodule

// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte master for the SD command path; MSB-first, full duplex.
module spi_byte_master
    import sd_spi_pkg::*;
#(
    parameter int DIV_SLOW = SD_DIV_SLOW,
    parameter int DIV_FAST = SD_DIV_FAST
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_data,
    input  logic [SD_BYTE_W-1:0] data_in,
    input  logic                 speed_sel,
    input  logic                 cs_in,
    output logic [SD_BYTE_W-1:0] data_out,
    output logic                 busy,
    output logic                 sclk,
    output logic                 mosi,
    input  logic                 miso,
    output logic                 ss_n
);

    spi_state_t           state;
    logic [SD_BYTE_W-1:0] tx_shift;
    logic [SD_BYTE_W-1:0] rx_shift;
    logic [7:0]           div_q;
    logic [2:0]           bit_cnt;
    logic                 div_clr;
    logic                 tick;

    assign div_clr = (state == IDLE) || (state == LOAD);

    spi_clk_div u_clk_div (
        .clk   (clk),
        .reset (reset),
        .clr   (div_clr),
        .div   (div_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b1;
            ss_n     <= 1'b1;
            data_out <= '1;
            tx_shift <= '1;
            rx_shift <= '1;
            div_q    <= 8'(DIV_SLOW);
            bit_cnt  <= '0;
        end else begin
            ss_n <= cs_in;
            case (state)
                IDLE: begin
                    sclk <= 1'b0;
                    mosi <= 1'b1;
                    if (w_data) begin
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    tx_shift <= data_in;
                    mosi     <= data_in[SD_BYTE_W-1];
                    div_q    <= speed_sel ? 8'(DIV_FAST) : 8'(DIV_SLOW);
                    bit_cnt  <= '0;
                    state    <= LOW;
                end
                LOW: begin
                    if (tick) begin
                        sclk     <= 1'b1;
                        rx_shift <= {rx_shift[SD_BYTE_W-2:0], miso};
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            data_out <= rx_shift;
                            busy     <= 1'b0;
                            mosi     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            tx_shift <= {tx_shift[SD_BYTE_W-2:0], 1'b1};
                            mosi     <= tx_shift[SD_BYTE_W-2];
                            state    <= LOW;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Self-checking bench for spi_byte_master: vector table plus corner-case sequences.
module tb_spi_byte_master;

    localparam int CLK_P = 10;
    localparam int DIV_S = 125;
    localparam int DIV_F = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       w_data;
    logic [7:0] data_in;
    logic       speed_sel;
    logic       cs_in;
    logic [7:0] data_out;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;

    logic       loopback;
    logic [7:0] resp_byte;
    int         rise_base;
    int         rises = 0;
    time        rise_t [64];
    logic [31:0] mosi_hist = '0;
    logic [2:0] bit_idx;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] tx;
        logic       sp;
        logic       lb;
        logic [7:0] rsp;
        logic [7:0] exp;
        int         cycles;
    } vec_t;

    vec_t vecs [5];

    always #(CLK_P/2) clk = ~clk;

    // SD card model: response MSB first, one bit per SCK rise; loopback ties miso to mosi.
    assign bit_idx = 3'(rises - rise_base);
    assign miso    = loopback ? mosi : resp_byte[3'd7 - bit_idx];

    always @(posedge sclk) begin
        rise_t[rises % 64] = $time;
        mosi_hist = {mosi_hist[30:0], mosi};
        rises = rises + 1;
    end

    spi_byte_master #(
        .DIV_SLOW (DIV_S),
        .DIV_FAST (DIV_F)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .w_data    (w_data),
        .data_in   (data_in),
        .speed_sel (speed_sel),
        .cs_in     (cs_in),
        .data_out  (data_out),
        .busy      (busy),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: strobe lands on the following posedge (edge N).
    task automatic strobe_now(input logic [7:0] tx, input logic sp);
        w_data    = 1'b1;
        data_in   = tx;
        speed_sel = sp;
        rise_base = rises;
        @(negedge clk);
        w_data = 1'b0;
        chk("busy_after_strobe", {31'd0, busy}, 32'd1);
    endtask

    task automatic strobe(input logic [7:0] tx, input logic sp);
        @(negedge clk);
        strobe_now(tx, sp);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_rx(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty, got %0h", name, data_out);
        end else begin
            e = exp_q.pop_front();
            chk(name, {24'd0, data_out}, {24'd0, e});
        end
    endtask

    initial begin
        int cyc;
        int base0;
        int per;
        int wait_cyc;

        vecs[0] = '{tx: 8'hA5, sp: 1'b1, lb: 1'b1, rsp: 8'h00, exp: 8'hA5, cycles: 1 + 16*DIV_F};
        vecs[1] = '{tx: 8'h40, sp: 1'b1, lb: 1'b0, rsp: 8'h01, exp: 8'h01, cycles: 1 + 16*DIV_F};
        vecs[2] = '{tx: 8'hFF, sp: 1'b0, lb: 1'b1, rsp: 8'h00, exp: 8'hFF, cycles: 1 + 16*DIV_S};
        vecs[3] = '{tx: 8'h3C, sp: 1'b1, lb: 1'b0, rsp: 8'hC3, exp: 8'hC3, cycles: 1 + 16*DIV_F};
        vecs[4] = '{tx: 8'h00, sp: 1'b1, lb: 1'b1, rsp: 8'hFF, exp: 8'h00, cycles: 1 + 16*DIV_F};

        reset     = 1'b0;
        w_data    = 1'b0;
        data_in   = 8'h00;
        speed_sel = 1'b0;
        cs_in     = 1'b1;
        loopback  = 1'b1;
        resp_byte = 8'hFF;
        rise_base = 0;

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd1);
        chk("rst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("rst_data_out", {24'd0, data_out}, 32'hFF);

        cs_in = 1'b0;
        @(negedge clk);
        chk("ss_n_follow", {31'd0, ss_n}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            loopback  = vecs[i].lb;
            resp_byte = vecs[i].rsp;
            exp_q.push_back(vecs[i].exp);
            strobe(vecs[i].tx, vecs[i].sp);
            wait_done(cyc);
            chk($sformatf("v%0d_latency", i), cyc, vecs[i].cycles);
            check_rx($sformatf("v%0d_data_out", i));
            chk($sformatf("v%0d_mosi", i), {24'd0, mosi_hist[7:0]}, {24'd0, vecs[i].tx});
            chk($sformatf("v%0d_pulses", i), rises - rise_base, 8);
            per = int'((rise_t[(rise_base + 7) % 64] - rise_t[rise_base % 64]) / 7);
            chk($sformatf("v%0d_sck_period", i), per, 2 * CLK_P * (vecs[i].sp ? DIV_F : DIV_S));
            chk($sformatf("v%0d_idle_mosi", i), {31'd0, mosi}, 32'd1);
        end

        // Back-to-back bytes with an ignored strobe in the middle of the first.
        loopback = 1'b1;
        base0    = rises;
        exp_q.push_back(8'h12);
        strobe(8'h12, 1'b1);
        repeat (8) @(negedge clk);
        w_data  = 1'b1;
        data_in = 8'hEE;
        @(negedge clk);
        w_data = 1'b0;
        wait_done(cyc);
        check_rx("b2b_first");
        exp_q.push_back(8'h34);
        strobe_now(8'h34, 1'b1);
        wait_done(cyc);
        chk("b2b_latency", cyc, 1 + 16*DIV_F);
        check_rx("b2b_second");
        repeat (60) @(negedge clk);
        chk("b2b_pulses", rises - base0, 16);
        chk("b2b_mosi", {16'd0, mosi_hist[15:0]}, 32'h1234);
        chk("b2b_no_third", {31'd0, busy}, 32'd0);

        // Asynchronous reset after three bits, then a clean transfer.
        strobe(8'hC6, 1'b1);
        wait_cyc = 0;
        while (rises - rise_base < 3 && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("mid_reach_bit3", {31'd0, (rises - rise_base >= 3)}, 32'd1);
        @(negedge clk);
        chk("mid_ss_n_pre", {31'd0, ss_n}, 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        chk("mid_rst_mosi", {31'd0, mosi}, 32'd1);
        chk("mid_rst_ss_n", {31'd0, ss_n}, 32'd1);
        chk("mid_rst_data_out", {24'd0, data_out}, 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        exp_q.push_back(8'h5A);
        strobe(8'h5A, 1'b1);
        wait_done(cyc);
        chk("post_latency", cyc, 1 + 16*DIV_F);
        check_rx("post_data_out");
        chk("post_mosi", {24'd0, mosi_hist[7:0]}, 32'h5A);
        chk("post_pulses", rises - rise_base, 8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
